// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller state encoding, round constants,
// GF(2^8) doubling and the forward S-box.
package aes_pkg;

  localparam int AES_NR = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } aes_state_e;

  // Forward S-box, entry 0x00 in the top byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[(11'd2047 - {b, 3'b000}) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES-128 encryption round plus the matching on-the-fly
// key-schedule step; the caller registers both results.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  input  logic         last_round,
  input  logic [7:0]   rc,
  output logic [127:0] next_state,
  output logic [127:0] next_key
);

  logic [31:0]  w3_s;
  logic [31:0]  temp_s;
  logic [127:0] shifted_s;
  logic [127:0] mixed_s;

  assign w3_s   = round_key[31:0];
  assign temp_s = {sbox(w3_s[23:16]), sbox(w3_s[15:8]), sbox(w3_s[7:0]), sbox(w3_s[31:24])}
                  ^ {rc, 24'h000000};

  assign next_key[127:96] = round_key[127:96] ^ temp_s;
  assign next_key[95:64]  = round_key[95:64]  ^ next_key[127:96];
  assign next_key[63:32]  = round_key[63:32]  ^ next_key[95:64];
  assign next_key[31:0]   = round_key[31:0]   ^ next_key[63:32];

  // Byte (r,c) sits at index r+4c; ShiftRows pulls row r from column c+r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign shifted_s[127-8*(4*c+r) -: 8] = sbox(state[127-8*(4*((c+r)%4)+r) -: 8]);
    end

    logic [7:0] a0_s, a1_s, a2_s, a3_s;
    assign a0_s = shifted_s[127-32*c -: 8];
    assign a1_s = shifted_s[119-32*c -: 8];
    assign a2_s = shifted_s[111-32*c -: 8];
    assign a3_s = shifted_s[103-32*c -: 8];

    assign mixed_s[127-32*c -: 8] = xtime(a0_s) ^ xtime(a1_s) ^ a1_s ^ a2_s ^ a3_s;
    assign mixed_s[119-32*c -: 8] = a0_s ^ xtime(a1_s) ^ xtime(a2_s) ^ a2_s ^ a3_s;
    assign mixed_s[111-32*c -: 8] = a0_s ^ a1_s ^ xtime(a2_s) ^ xtime(a3_s) ^ a3_s;
    assign mixed_s[103-32*c -: 8] = xtime(a0_s) ^ a0_s ^ a1_s ^ a2_s ^ xtime(a3_s);
  end

  assign next_state = (last_round ? shifted_s : mixed_s) ^ next_key;

endmodule

// File: rtl/aes_iter_enc_ctrl.sv
// Iterative AES-128 encryptor: one round per clock, round keys derived on the
// fly, ciphertext held until the consumer takes it.
module aes_iter_enc_ctrl
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic [127:0] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy,
  output logic [3:0]   round
);

  if (NR != AES_NR) begin : g_bad_nr
    $error("aes_iter_enc_ctrl: only NR = 10 (AES-128) is supported");
  end

  localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

  aes_state_e   fsm_r, fsm_nxt_s;
  logic [127:0] data_r;
  logic [127:0] key_r;
  logic [127:0] out_block_r;
  logic [3:0]   round_r;
  logic         last_round_s;
  logic [127:0] rnd_state_s;
  logic [127:0] rnd_key_s;

  assign last_round_s = (round_r == LAST_ROUND);

  aes_round u_round (
    .state      (data_r),
    .round_key  (key_r),
    .last_round (last_round_s),
    .rc         (rcon(round_r)),
    .next_state (rnd_state_s),
    .next_key   (rnd_key_s)
  );

  // Next-state decode for the IDLE/RUN/DONE controller.
  always_comb begin
    fsm_nxt_s = fsm_r;
    case (fsm_r)
      ST_IDLE: if (in_valid)     fsm_nxt_s = ST_RUN;  else fsm_nxt_s = ST_IDLE;
      ST_RUN:  if (last_round_s) fsm_nxt_s = ST_DONE; else fsm_nxt_s = ST_RUN;
      ST_DONE: if (out_ready)    fsm_nxt_s = ST_IDLE; else fsm_nxt_s = ST_DONE;
      default: fsm_nxt_s = ST_IDLE;
    endcase
  end

  // State, datapath and result registers; reset also aborts a running block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r       <= ST_IDLE;
      data_r      <= 128'h0;
      key_r       <= 128'h0;
      out_block_r <= 128'h0;
      round_r     <= 4'd0;
    end else begin
      fsm_r <= fsm_nxt_s;
      case (fsm_r)
        ST_IDLE: begin
          if (in_valid) begin
            data_r  <= in_block ^ in_key;
            key_r   <= in_key;
            round_r <= 4'd1;
          end
        end
        ST_RUN: begin
          data_r <= rnd_state_s;
          key_r  <= rnd_key_s;
          if (last_round_s) begin
            out_block_r <= rnd_state_s;
            round_r     <= 4'd0;
          end else begin
            round_r <= round_r + 4'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign in_ready  = (fsm_r == ST_IDLE);
  assign out_valid = (fsm_r == ST_DONE);
  assign busy      = (fsm_r != ST_IDLE);
  assign round     = round_r;
  assign out_block = out_block_r;

endmodule

// File: tb/tb_aes_iter_enc_ctrl.sv
// Self-checking bench for aes_iter_enc_ctrl: FIPS-197 vectors, backpressure,
// ignored input, mid-run reset, back-to-back and random blocks vs. a reference AES.
module tb_aes_iter_enc_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_block;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_block;
  logic         busy;
  logic [3:0]   round;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] sbox_m [256];

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  always #5 clk = ~clk;

  aes_iter_enc_ctrl #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy),
    .round     (round)
  );

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    logic [7:0] r;
    r = (v << n) | (v >> (8 - n));
    return r;
  endfunction

  // Reference AES-128: full key expansion up front, state as a 4x4 byte matrix.
  function automatic logic [127:0] ref_aes(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   w [44][4];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   tmp [4];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = key[127-8*(4*i+j) -: 8];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
      if (i % 4 == 0) begin
        for (int j = 0; j < 4; j++) tmp[j] = sbox_m[w[i-1][(j+1)%4]];
        tmp[0] = tmp[0] ^ rc;
        rc = gmul(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = pt[127-8*(r+4*c) -: 8] ^ w[c][r];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) t[r][c] = sbox_m[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rnd < 10)
            s[r][c] = gmul(8'h02, t[r][c]) ^ gmul(8'h03, t[(r+1)%4][c])
                      ^ t[(r+2)%4][c] ^ t[(r+3)%4][c];
          else
            s[r][c] = t[r][c];
        end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) s[r][c] = s[r][c] ^ w[4*rnd+c][r];
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) res[127-8*(r+4*c) -: 8] = s[r][c];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Offer one block, follow it through RUN/DONE and release it after bp stalled cycles.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input int bp, input bit glitch);
    int n;
    int lat;
    in_key   = key;
    in_block = pt;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    check_eq("accept_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_block = ~pt;
    in_key   = ~key;
    check_eq("busy_after_accept", busy, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      check_eq("round_idx", round, 128'(lat + 1));
      check_eq("in_ready_run", in_ready, 1'b0);
      if (glitch && lat == 3) begin
        in_valid = 1'b1;
        in_block = rand128();
        in_key   = rand128();
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
      lat++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("latency", lat, 10);
    check_eq("ciphertext", out_block, exp);
    check_eq("round_done", round, 4'd0);
    for (int i = 0; i < bp; i++) begin
      step();
      check_eq("bp_valid", out_valid, 1'b1);
      check_eq("bp_block", out_block, exp);
      check_eq("bp_in_ready", in_ready, 1'b0);
      check_eq("bp_busy", busy, 1'b1);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_eq("idle_valid", out_valid, 1'b0);
    check_eq("idle_in_ready", in_ready, 1'b1);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_block_kept", out_block, exp);
    check_eq("idle_round", round, 4'd0);
  endtask

  initial begin
    logic [7:0]   inv;
    logic [127:0] k;
    logic [127:0] p;
    logic [127:0] kq [4];
    logic [127:0] pq [4];
    logic [127:0] exp_q [$];
    int           acc_cyc [$];
    int           n;
    int           idx;
    int           got;
    bit           accepted;
    bit           any_valid;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_block  = 128'h0;
    in_key    = 128'h0;
    step();
    step();
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_round", round, 4'd0);
    check_eq("rst_out_block", out_block, 128'h0);
    rst_n = 1'b1;
    step();
    check_eq("post_rst_in_ready", in_ready, 1'b1);

    run_block(C1_KEY, C1_PT, C1_CT, 0, 1'b0);
    run_block(B_KEY, B_PT, B_CT, 5, 1'b0);
    run_block(C1_KEY, C1_PT, C1_CT, 2, 1'b1);

    // Reset in the middle of round 5.
    in_key   = B_KEY;
    in_block = B_PT;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      step();
      n++;
    end
    step();
    in_valid = 1'b0;
    n = 0;
    while (round != 4'd5 && n < 20) begin
      step();
      n++;
    end
    check_eq("reached_round5", round, 4'd5);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("abort_out_valid", out_valid, 1'b0);
    check_eq("abort_round", round, 4'd0);
    check_eq("abort_out_block", out_block, 128'h0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_in_ready", in_ready, 1'b1);
    any_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      any_valid = any_valid | out_valid;
    end
    check_eq("abort_no_valid", any_valid, 1'b0);
    run_block(C1_KEY, C1_PT, C1_CT, 1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      k = rand128();
      p = rand128();
      run_block(k, p, ref_aes(k, p), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Back-to-back: in_valid and out_ready held high.
    kq[0] = C1_KEY;
    pq[0] = C1_PT;
    kq[1] = B_KEY;
    pq[1] = B_PT;
    kq[2] = rand128();
    pq[2] = rand128();
    kq[3] = rand128();
    pq[3] = rand128();
    idx = 0;
    got = 0;
    in_key    = kq[0];
    in_block  = pq[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 80 && got < 4; c++) begin
      accepted = in_ready && in_valid;
      if (accepted) begin
        acc_cyc.push_back(c);
        exp_q.push_back(ref_aes(in_key, in_block));
      end
      step();
      if (accepted) begin
        idx++;
        if (idx < 4) begin
          in_key   = kq[idx];
          in_block = pq[idx];
        end else begin
          in_valid = 1'b0;
        end
      end
      if (out_valid) begin
        if (exp_q.size() > 0) check_eq("b2b_ct", out_block, exp_q.pop_front());
        else check_eq("b2b_unexpected_valid", out_valid, 1'b0);
        got++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("b2b_count", got, 4);
    check_eq("b2b_accepts", acc_cyc.size(), 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      check_eq("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 12);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_iter_enc_ctrl.md
AES_ITER_ENC_CTRL -- requirements
Module: aes_iter_enc_ctrl

Interface
REQ-001 SHALL have parameter: NR, 10, number of cipher rounds; only 10 (AES-128) is legal, other values are an elaboration error.
REQ-002 SHALL have port: clk  input  1  single clock, all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  plaintext/key offered.
REQ-005 SHALL have port: in_ready  output  1  controller can accept a block.
REQ-006 SHALL have port: in_block  input  128  plaintext, FIPS-197 byte 0 at [127:120].
REQ-007 SHALL have port: in_key  input  128  cipher key, byte 0 at [127:120].
REQ-008 SHALL have port: out_valid  output  1  ciphertext available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts ciphertext.
REQ-010 SHALL have port: out_block  output  128  ciphertext, byte 0 at [127:120].
REQ-011 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port: round  output  4  current round index, 0 in IDLE/DONE.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 SHALL assert in_ready only in IDLE; input accepted on in_valid && in_ready.
REQ-015 SHALL, on accept at edge T, load state register = in_block XOR in_key, round key register = in_key, round = 1, go to RUN.
REQ-016 SHALL sample in_block/in_key only at the accept edge; later changes have no effect.
REQ-017 SHALL in RUN, per cycle: compute next round key from current round key with Rcon(round), apply SubBytes, ShiftRows, MixColumns (skipped when round == NR), AddRoundKey with that next key; register result; increment round.
REQ-018 SHALL generate round keys on the fly, one per cycle; no 11-key storage.
REQ-019 SHALL use Rcon sequence 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10 in the key word's top byte.
REQ-020 SHALL move RUN->DONE on the edge that completes round NR; out_valid rises at edge T+NR (10 cycles after accept).
REQ-021 SHALL hold out_block and out_valid stable in DONE until out_valid && out_ready.
REQ-022 SHALL return DONE->IDLE on that handshake; in_ready high the following cycle (minimum 12-cycle block spacing).
REQ-023 SHALL ignore in_valid when not in IDLE (no queuing, no state change).
REQ-024 SHALL ignore out_ready when out_valid is low.
REQ-025 SHALL keep out_block equal to last ciphertext while in IDLE; out_valid low.
REQ-026 SHALL produce X-free outputs for all cycles after reset.

Reset
REQ-027 SHALL, on rst_n low at a clock edge, go to IDLE; state, round key, out_block = 0; round = 0; out_valid, busy = 0; in_ready = 1 from the first cycle after reset release.
REQ-028 SHALL abort an in-flight encryption on reset without emitting out_valid.

Structure
REQ-029 SHALL place FSM state enum, Rcon table, NR constant and GF(2^8) xtime helper in shared package aes_pkg.
REQ-030 SHALL instantiate one combinational sub-module aes_round (inputs state, round key, last-round flag, Rcon; outputs next state, next round key), reusing the codebase S-box, SubBytes and ShiftRows blocks.
REQ-031 SHALL keep all registers in aes_iter_enc_ctrl; aes_round has no clock.

Verification
REQ-032 SHALL check FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> out_block 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at accept+10.
REQ-033 SHALL check FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> 3925841d02dc09fbdc118597196a0b32.
REQ-034 SHALL check backpressure: out_ready low 5 cycles after out_valid -> out_block/out_valid stable, in_ready low, busy high throughout.
REQ-035 SHALL check in_valid pulsed with a different block during RUN -> ignored, result still matches first block.
REQ-036 SHALL check rst_n low at round 5 -> next cycle IDLE, out_valid 0, round 0, out_block 0; subsequent C.1 run correct.
REQ-037 SHALL check back-to-back: in_valid held high with out_ready high -> accepts spaced exactly 12 cycles, each ciphertext correct.
